mvu_bitplane_tx: RTL and testbench

- Drains the n parallel accumulator results of the matrix-vector unit and re-encodes them as bit-serial planes, so that the next layer's D input can consume them.
- On a load strobe it captures all n accumulators, requantizes each one, and stores the result.
- Requantization is: right shift by a programmable amount, then saturate to p bits.
- It then transmits p planes of n bits each, MSB plane first, over a valid/ready handshake.

---
 rtl/mvu_pkg.sv | 24 ++
 rtl/mvu_quant.sv | 43 ++++
 rtl/mvu_bitplane_tx.sv | 108 ++++++++++
 tb/tb_mvu_bitplane_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared encodings, defaults and width helpers for the MVU bit-plane transmitter.
package mvu_pkg;

  localparam int MVU_N = 64;
  localparam int MVU_W = 32;
  localparam int MVU_P = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  function automatic int mvu_sw(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int mvu_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Plane index width; a single-plane build still needs a 1-bit index.
  function automatic int mvu_kw(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/mvu_quant.sv
// Per-lane requantizer: shift right by shamt, then clamp into the p-bit
// signed or unsigned output range.
module mvu_quant
  import mvu_pkg::*;
#(
  parameter int w = MVU_W,
  parameter int p = MVU_P
) (
  input  logic [w-1:0]          x,
  input  logic [mvu_sw(w)-1:0]  shamt,
  input  logic                  sgn,
  output logic [p-1:0]          q,
  output logic                  sat
);

  // Limits live in w+1 signed bits so 2^p-1 stays positive even when p==w.
  localparam logic [w:0]        ONE  = {{w{1'b0}}, 1'b1};
  localparam logic signed [w:0] UMAX = signed'((ONE << p) - ONE);
  localparam logic signed [w:0] SMAX = signed'((ONE << (p - 1)) - ONE);
  localparam logic signed [w:0] SMIN = ~SMAX;

  logic [w-1:0]        y;
  logic signed [w:0]   ys, hi, lo, c;

  always_comb begin
    if (sgn) y = $unsigned($signed(x) >>> shamt);
    else     y = x >> shamt;
    ys  = sgn ? signed'({y[w-1], y}) : signed'({1'b0, y});
    hi  = sgn ? SMAX : UMAX;
    lo  = sgn ? SMIN : '0;
    c   = ys;
    sat = 1'b0;
    if (ys > hi) begin
      c   = hi;
      sat = 1'b1;
    end else if (ys < lo) begin
      c   = lo;
      sat = 1'b1;
    end
    q = c[p-1:0];
  end

endmodule

// File: rtl/mvu_bitplane_tx.sv
// Captures n accumulators, requantizes them to p bits and streams them out as
// p bit-planes, MSB first. Optional clamp counter: MVU_TX_SATCNT_EN.
module mvu_bitplane_tx
  import mvu_pkg::*;
#(
  parameter int n = MVU_N,
  parameter int w = MVU_W,
  parameter int p = MVU_P
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [n*w-1:0]        I,
  input  logic                  ld,
  input  logic [mvu_sw(w)-1:0]  shamt,
  input  logic                  sgn,
  output logic                  busy,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [n-1:0]          O,
  output logic                  olast
`ifdef MVU_TX_SATCNT_EN
  , output logic [mvu_cw(n)-1:0] satcnt
`endif
);

  localparam int KW = mvu_kw(p);
  localparam int CW = mvu_cw(n);

  logic [0:0]            state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [n-1:0][p-1:0]   vec_q, vec_d, qv;
  logic [n-1:0]          sat;
  logic                  cap;

  for (genvar i = 0; i < n; i++) begin : g_lane
    mvu_quant #(.w(w), .p(p)) u_quant (
      .x     (I[i*w +: w]),
      .shamt (shamt),
      .sgn   (sgn),
      .q     (qv[i]),
      .sat   (sat[i])
    );
  end

  // ld is only looked at in IDLE, so a load coinciding with the last beat waits a cycle.
  assign cap = (state_q == IDLE) && ld;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: if (ld) begin
        state_d = SEND;
        k_d     = KW'(p - 1);
        vec_d   = qv;
      end
      default: if (oready) begin
        if (k_q == '0) state_d = IDLE;
        else           k_d     = k_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      k_q     <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
    end
  end

  assign busy   = (state_q == SEND);
  assign ovalid = busy;
  assign olast  = busy && (k_q == '0);

  always_comb begin
    O = '0;
    for (int i = 0; i < n; i++) O[i] = busy & vec_q[i][k_q];
  end

`ifdef MVU_TX_SATCNT_EN
  logic [CW-1:0] satcnt_q, satcnt_d;

  always_comb begin
    satcnt_d = satcnt_q;
    if (cap) begin
      satcnt_d = '0;
      for (int i = 0; i < n; i++) satcnt_d = satcnt_d + CW'(sat[i]);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) satcnt_q <= '0;
    else     satcnt_q <= satcnt_d;
  end

  assign satcnt = satcnt_q;
`else
  logic unused_sat;
  assign unused_sat = ^{sat, cap, CW[0]};
`endif

endmodule

// File: tb/tb_mvu_bitplane_tx.sv
// Directed bench for mvu_bitplane_tx at n=4, w=8, p=2.
module tb_mvu_bitplane_tx;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           clr;
  logic [N*W-1:0] I;
  logic           ld;
  logic [2:0]     shamt;
  logic           sgn;
  logic           busy, ovalid, oready, olast;
  logic [N-1:0]   O;
`ifdef MVU_TX_SATCNT_EN
  logic [2:0]     satcnt;
`endif

  int total  = 0;
  int passed = 0;

  mvu_bitplane_tx #(.n(N), .w(W), .p(P)) dut (
    .clk    (clk),
    .clr    (clr),
    .I      (I),
    .ld     (ld),
    .shamt  (shamt),
    .sgn    (sgn),
    .busy   (busy),
    .ovalid (ovalid),
    .oready (oready),
    .O      (O),
    .olast  (olast)
`ifdef MVU_TX_SATCNT_EN
    , .satcnt (satcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Checks the visible plane outputs in one go.
  task automatic beat(input string tag, input logic [3:0] o, input logic lst);
    chk({tag, ".ovalid"}, 32'(ovalid), 32'd1);
    chk({tag, ".O"},      32'(O),      32'(o));
    chk({tag, ".olast"},  32'(olast),  32'(lst));
  endtask

  initial begin
    clr = 1'b1; ld = 1'b0; oready = 1'b0; sgn = 1'b0; shamt = '0; I = '0;
    #1;
    chk("rst.busy",   32'(busy),   32'd0);
    chk("rst.ovalid", 32'(ovalid), 32'd0);
    chk("rst.olast",  32'(olast),  32'd0);
    chk("rst.O",      32'(O),      32'd0);
`ifdef MVU_TX_SATCNT_EN
    chk("rst.satcnt", 32'(satcnt), 32'd0);
`endif
    @(negedge clk); clr = 1'b0;

    // unsigned, no shift: lanes {3,1,2,0}
    @(negedge clk);
    I = {8'd0, 8'd2, 8'd1, 8'd3}; sgn = 1'b0; shamt = 3'd0; oready = 1'b1; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
    beat("u.b1", 4'b0101, 1'b0);
    chk("u.busy1", 32'(busy), 32'd1);
`ifdef MVU_TX_SATCNT_EN
    chk("u.satcnt", 32'(satcnt), 32'd0);
`endif
    @(negedge clk);
    beat("u.b2", 4'b0011, 1'b1);
    @(negedge clk);
    chk("u.busy_end",   32'(busy),   32'd0);
    chk("u.ovalid_end", 32'(ovalid), 32'd0);

    // signed with saturation: {1,-2,1,-1}
    I = {8'hFC, 8'h04, 8'hC0, 8'h40}; sgn = 1'b1; shamt = 3'd2; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
    beat("s.b1", 4'b1010, 1'b0);
`ifdef MVU_TX_SATCNT_EN
    chk("s.satcnt", 32'(satcnt), 32'd2);
`endif
    @(negedge clk);
    beat("s.b2", 4'b1101, 1'b1);
    @(negedge clk);
    chk("s.busy_end", 32'(busy), 32'd0);

    // backpressure, with a conflicting ld during SEND
    I = {8'd0, 8'd2, 8'd1, 8'd3}; sgn = 1'b0; shamt = 3'd0; oready = 1'b0; ld = 1'b1;
    @(negedge clk);
    I = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; sgn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      beat($sformatf("bp.hold%0d", c), 4'b0101, 1'b0);
      @(negedge clk);
    end
    ld = 1'b0; oready = 1'b1;
    beat("bp.hold5", 4'b0101, 1'b0);
    @(negedge clk);
    beat("bp.b2", 4'b0011, 1'b1);

    // ld on the final handshake is ignored; held high, it lands one cycle later
    I = {8'd0, 8'd0, 8'd0, 8'hFF}; sgn = 1'b0; shamt = 3'd0; ld = 1'b1;
    @(negedge clk);
    chk("fl.busy_gap", 32'(busy), 32'd0);
    @(negedge clk); ld = 1'b0;
    beat("uc.b1", 4'b0001, 1'b0);
`ifdef MVU_TX_SATCNT_EN
    chk("uc.satcnt", 32'(satcnt), 32'd1);
`endif
    @(negedge clk);
    beat("uc.b2", 4'b0001, 1'b1);
    @(negedge clk);
    chk("uc.busy_end", 32'(busy), 32'd0);

    // reset mid-transfer clears outputs without a clock edge
    I = {8'hFC, 8'h04, 8'hC0, 8'h40}; sgn = 1'b1; shamt = 3'd2; oready = 1'b0; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
    beat("mr.b1", 4'b1010, 1'b0);
    #2 clr = 1'b1;
    #1;
    chk("mr.ovalid", 32'(ovalid), 32'd0);
    chk("mr.busy",   32'(busy),   32'd0);
    chk("mr.O",      32'(O),      32'd0);
`ifdef MVU_TX_SATCNT_EN
    chk("mr.satcnt", 32'(satcnt), 32'd0);
`endif
    @(negedge clk); clr = 1'b0;
    I = {8'd0, 8'd2, 8'd1, 8'd3}; sgn = 1'b0; shamt = 3'd0; oready = 1'b1; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
    beat("mr.n1", 4'b0101, 1'b0);
    @(negedge clk);
    beat("mr.n2", 4'b0011, 1'b1);
    @(negedge clk);
    chk("mr.busy_end", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
